// File: rtl/dtc_tree_engine.sv
// dtc_tree_engine: programmable sequential decision-tree classifier.
// A writable node table holds the tree. Each accepted sample walks from
// node 0, evaluating one node per clock, until it reaches a leaf or has
// taken DEPTH branch decisions. Samples and results use valid/ready.
module dtc_tree_engine #(
   parameter int IN_W  = 7,
   parameter int OUT_W = 10,
   parameter int NODES = 16,
   parameter int DEPTH = 8,
   localparam int FW      = (IN_W > 1) ? $clog2(IN_W) : 1,
   localparam int IW      = $clog2(NODES),
   localparam int ENTRY_W = 1 + FW + 2*IW + OUT_W,
   localparam int SW      = $clog2(DEPTH + 1)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               cfg_we,
   input  logic [IW-1:0]      cfg_addr,
   input  logic [ENTRY_W-1:0] cfg_data,
   output logic               cfg_busy,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [IN_W-1:0]    inp,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [OUT_W-1:0]   outp,
   output logic               out_err,
   output logic [SW-1:0]      out_steps
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_WALK = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [ENTRY_W-1:0] table_q [NODES];

   logic [1:0]       state_q,  state_d;
   logic [IN_W-1:0]  inp_q,    inp_d;
   logic [IW-1:0]    cur_q,    cur_d;
   logic [SW-1:0]    steps_q,  steps_d;
   logic             ovalid_q, ovalid_d;
   logic [OUT_W-1:0] outp_q,   outp_d;
   logic             oerr_q,   oerr_d;
   logic [SW-1:0]    ostep_q,  ostep_d;

   // Fields of the node currently being evaluated
   logic [ENTRY_W-1:0] entry;
   logic               ent_branch;
   logic [FW-1:0]      ent_feat;
   logic [IW-1:0]      ent_left;
   logic [IW-1:0]      ent_right;
   logic [OUT_W-1:0]   ent_leaf;
   logic               feat_bit;
   logic [IW-1:0]      next_idx;

   // Decode the current node; out-of-range feature indices read as 0
   always_comb begin
      entry      = table_q[cur_q];
      ent_leaf   = entry[OUT_W-1:0];
      ent_right  = entry[OUT_W+IW-1:OUT_W];
      ent_left   = entry[OUT_W+2*IW-1:OUT_W+IW];
      ent_feat   = entry[OUT_W+2*IW+FW-1:OUT_W+2*IW];
      ent_branch = entry[ENTRY_W-1];
      feat_bit   = 1'b0;
      if (32'(ent_feat) < IN_W) begin
         feat_bit = inp_q[ent_feat];
      end
      next_idx = feat_bit ? ent_right : ent_left;
   end

   // Walk FSM next-state and registered-output logic
   always_comb begin
      state_d  = state_q;
      inp_d    = inp_q;
      cur_d    = cur_q;
      steps_d  = steps_q;
      ovalid_d = ovalid_q;
      outp_d   = outp_q;
      oerr_d   = oerr_q;
      ostep_d  = ostep_q;
      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               inp_d   = inp;
               cur_d   = '0;
               steps_d = '0;
               state_d = S_WALK;
            end
         end
         S_WALK: begin
            if (!ent_branch) begin
               outp_d   = ent_leaf;
               oerr_d   = 1'b0;
               ostep_d  = steps_q;
               ovalid_d = 1'b1;
               state_d  = S_DONE;
            end else if (steps_q == SW'(DEPTH)) begin
               outp_d   = '0;
               oerr_d   = 1'b1;
               ostep_d  = SW'(DEPTH);
               ovalid_d = 1'b1;
               state_d  = S_DONE;
            end else begin
               cur_d   = next_idx;
               steps_d = steps_q + SW'(1);
            end
         end
         S_DONE: begin
            if (out_ready) begin
               ovalid_d = 1'b0;
               state_d  = S_IDLE;
            end
         end
         default: begin
            ovalid_d = 1'b0;
            state_d  = S_IDLE;
         end
      endcase
   end

   // FSM and output registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_IDLE;
         inp_q    <= '0;
         cur_q    <= '0;
         steps_q  <= '0;
         ovalid_q <= 1'b0;
         outp_q   <= '0;
         oerr_q   <= 1'b0;
         ostep_q  <= '0;
      end else begin
         state_q  <= state_d;
         inp_q    <= inp_d;
         cur_q    <= cur_d;
         steps_q  <= steps_d;
         ovalid_q <= ovalid_d;
         outp_q   <= outp_d;
         oerr_q   <= oerr_d;
         ostep_q  <= ostep_d;
      end
   end

   // Node table: cleared on reset, written only while idle
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned i = 0; i < NODES; i++) begin
            table_q[i] <= '0;
         end
      end else if (cfg_we && (state_q == S_IDLE)) begin
         table_q[cfg_addr] <= cfg_data;
      end
   end

   assign cfg_busy  = (state_q != S_IDLE);
   assign in_ready  = (state_q == S_IDLE);
   assign out_valid = ovalid_q;
   assign outp      = outp_q;
   assign out_err   = oerr_q;
   assign out_steps = ostep_q;

endmodule
